control_porton_multi: RTL and testbench
=======================================

// Module: control_porton_multi
// PURPOSE
//  Parametrised home-automation controller: decodes 4-bit remote commands (rx_data) for N_CH motorised
//  gates, each with open/closed limit switches, plus room light and intrusion alarm. Registered successor
//  of the single-gate combinational controller: adds a clock, per-gate FSM, motor timeout, reversal dead-time.
//  Sits between the serial receiver (rx_data/rx_valid) and the motor/light/alarm drivers.
// PARAMETERS
//  N_CH     2     number of gate channels, 1..4
//  T_MOTOR  1000  max cycles in OPENING/CLOSING before FAULT, >=2
//  T_DEAD   4     cycles both motor outputs held low before a direction reversal, >=1
//  T_LUZ    500   cycles light stays on after a sensor rising edge, >=1
// PORTS
//  clk                    in   1     single clock, all state on rising edge
//  rst                    in   1     synchronous reset, active high
//  rx_data                in   4     command: [3:2] opcode, [1:0] channel/sub-op
//  rx_valid               in   1     1-cycle strobe, rx_data valid; no backpressure
//  final_carrera_abierto  in   N_CH  open limit switch per gate (1 = reached)
//  final_carrera_cerrado  in   N_CH  closed limit switch per gate (1 = reached)
//  luz_switch             in   1     manual wall switch level
//  sensor                 in   1     presence sensor level
//  motor_abrir            out  N_CH  drive gate toward open
//  motor_cerrar           out  N_CH  drive gate toward closed
//  falla                  out  N_CH  gate in FAULT
//  luz                    out  1     light output
//  alarma                 out  1     latched alarm
// BEHAVIOUR
//  - Inputs are synchronous to clk. All outputs registered; reset value of every output 0.
//  - Commands (rx_valid=1): 00=OPEN ch, 01=CLOSE ch, 10=STOP ch, 11=system: 00 toggle light,
//    01 arm alarm, 10 disarm + clear alarm, 11 CLOSE all channels. ch>=N_CH: ignored, no effect.
//  - Gate FSM states: STOPPED, OPENING, OPEN, CLOSING, CLOSED, DEAD, FAULT. Reset -> STOPPED.
//  - STOPPED/OPEN/CLOSED: OPEN cmd -> OPENING unless abierto=1; CLOSE cmd -> CLOSING unless cerrado=1.
//    STOPPED with no cmd: abierto=1 -> OPEN, cerrado=1 -> CLOSED.
//  - Motor output asserts the cycle after the command cycle; drops the cycle after the limit is seen.
//  - OPENING: abierto=1 -> OPEN; CLOSE cmd -> DEAD (then CLOSING); OPEN cmd ignored. CLOSING symmetric.
//  - DEAD: both motors 0 for exactly T_DEAD cycles, then opposite direction; STOP during DEAD -> STOPPED.
//  - Timeout: cycle counter cleared on entering OPENING/CLOSING; T_MOTOR cycles without limit -> FAULT.
//  - abierto=1 and cerrado=1 together in any state -> FAULT next cycle.
//  - FAULT: motors 0, falla=1; exits only on STOP cmd to that ch -> STOPPED (falla 0 next cycle).
//  - Per-channel priority, same cycle: fault condition > STOP cmd > limit switch > OPEN/CLOSE cmd.
//  - motor_abrir[i] & motor_cerrar[i] never both 1 (hard invariant).
//  - Light: luz = luz_switch XOR toggle_ff OR auto_on. auto_on set on sensor 0->1 edge, held T_LUZ cycles;
//    new edge while held reloads counter. Toggle cmd flips toggle_ff.
//  - Alarm: armed and sensor=1 -> alarma=1 next cycle, latched; cleared only by disarm or rst.
//    Disarm and sensor=1 same cycle: disarm wins. Arm while sensor=1: alarma 1 on following cycle.
//  - rst mid-motion: motors 0, FSM STOPPED, counters/toggle/armed/alarma cleared, all in the rst cycle.
// STRUCTURE
//  - Package ctl_hogar_pkg: opcode and sys sub-op localparams, gate state encoding (3-bit).
//  - Sub-module canal_porton: one gate FSM + timeout/dead counters, instantiated N_CH times via generate.
//  - Top holds command decode, light timer, alarm latch.
// TESTING
//  - rst, then rx 0x0 (OPEN ch0), abierto[0]=1 at cycle 10 -> motor_abrir[0]=1 cycles 2..10, 0 from 11.
//  - CLOSING ch1, rx 0x1... reversal: rx 0x5 then 0x1 at cycle 5 -> both motors 0 for 4 cycles, then abrir.
//  - T_MOTOR=20, OPEN ch0, no limit -> falla[0]=1 after 20 motion cycles; rx 0x8 -> falla 0, STOPPED.
//  - abierto=cerrado=1 on ch1 while idle -> falla[1]=1 next cycle; motors stay 0.
//  - rx 0xD arm, sensor pulse -> alarma=1 latched + luz=1 for T_LUZ; rx 0xE -> alarma=0.
//  - rx 0x7 (ch3) with N_CH=2 -> no output change; rx 0xF -> all gates CLOSING; assert mutual exclusion.

Source files
------------

// File: rtl/ctl_hogar_pkg.sv
// rtl/ctl_hogar_pkg.sv - shared command opcodes and gate state encoding
package ctl_hogar_pkg;

  localparam logic [1:0] OP_OPEN  = 2'b00;
  localparam logic [1:0] OP_CLOSE = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_SYS   = 2'b11;

  localparam logic [1:0] SYS_LIGHT     = 2'b00;
  localparam logic [1:0] SYS_ARM       = 2'b01;
  localparam logic [1:0] SYS_DISARM    = 2'b10;
  localparam logic [1:0] SYS_CLOSE_ALL = 2'b11;

  localparam logic [2:0] ST_STOPPED = 3'd0;
  localparam logic [2:0] ST_OPENING = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_CLOSING = 3'd3;
  localparam logic [2:0] ST_CLOSED  = 3'd4;
  localparam logic [2:0] ST_DEAD    = 3'd5;
  localparam logic [2:0] ST_FAULT   = 3'd6;

endpackage

// File: rtl/canal_porton.sv
// rtl/canal_porton.sv - one gate FSM with motor timeout and reversal dead-time
module canal_porton
  import ctl_hogar_pkg::*;
#(
  parameter int T_MOTOR = 1000,
  parameter int T_DEAD  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_open_i,
  input  logic cmd_close_i,
  input  logic cmd_stop_i,
  input  logic abierto_i,
  input  logic cerrado_i,
  output logic motor_abrir_o,
  output logic motor_cerrar_o,
  output logic falla_o
);

  localparam int TMAX = (T_MOTOR > T_DEAD) ? T_MOTOR : T_DEAD;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] MOTOR_LAST = CW'(T_MOTOR - 1);
  localparam logic [CW-1:0] DEAD_LAST  = CW'(T_DEAD - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rev_open_q, rev_open_d;
  logic          abrir_q, cerrar_q, falla_q;

  // One counter serves both the motion timeout and the dead-time; it is cleared on every entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    rev_open_d = rev_open_q;
    if (abierto_i && cerrado_i) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (cmd_stop_i) state_d = ST_STOPPED;
    end else if (cmd_stop_i) begin
      state_d = ST_STOPPED;
    end else begin
      case (state_q)
        ST_STOPPED, ST_OPEN, ST_CLOSED: begin
          if (state_q == ST_STOPPED && abierto_i) begin
            state_d = ST_OPEN;
          end else if (state_q == ST_STOPPED && cerrado_i) begin
            state_d = ST_CLOSED;
          end else if (cmd_open_i && !abierto_i) begin
            state_d = ST_OPENING;
            cnt_d   = '0;
          end else if (cmd_close_i && !cerrado_i) begin
            state_d = ST_CLOSING;
            cnt_d   = '0;
          end
        end
        ST_OPENING: begin
          if (abierto_i) begin
            state_d = ST_OPEN;
          end else if (cnt_q == MOTOR_LAST) begin
            state_d = ST_FAULT;
          end else if (cmd_close_i) begin
            state_d    = ST_DEAD;
            cnt_d      = '0;
            rev_open_d = 1'b0;
          end
        end
        ST_CLOSING: begin
          if (cerrado_i) begin
            state_d = ST_CLOSED;
          end else if (cnt_q == MOTOR_LAST) begin
            state_d = ST_FAULT;
          end else if (cmd_open_i) begin
            state_d    = ST_DEAD;
            cnt_d      = '0;
            rev_open_d = 1'b1;
          end
        end
        ST_DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            cnt_d = '0;
            if (rev_open_q) state_d = abierto_i ? ST_OPEN : ST_OPENING;
            else            state_d = cerrado_i ? ST_CLOSED : ST_CLOSING;
          end
        end
        default: state_d = ST_STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STOPPED;
      cnt_q      <= '0;
      rev_open_q <= 1'b0;
      abrir_q    <= 1'b0;
      cerrar_q   <= 1'b0;
      falla_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rev_open_q <= rev_open_d;
      abrir_q    <= (state_d == ST_OPENING);
      cerrar_q   <= (state_d == ST_CLOSING);
      falla_q    <= (state_d == ST_FAULT);
    end
  end

  assign motor_abrir_o  = abrir_q;
  assign motor_cerrar_o = cerrar_q;
  assign falla_o        = falla_q;

endmodule

// File: rtl/control_porton_multi.sv
// rtl/control_porton_multi.sv - remote command decode, gate channels, light timer and alarm latch
module control_porton_multi
  import ctl_hogar_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int T_MOTOR = 1000,
  parameter int T_DEAD  = 4,
  parameter int T_LUZ   = 500
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      rx_data,
  input  logic            rx_valid,
  input  logic [N_CH-1:0] final_carrera_abierto,
  input  logic [N_CH-1:0] final_carrera_cerrado,
  input  logic            luz_switch,
  input  logic            sensor,
  output logic [N_CH-1:0] motor_abrir,
  output logic [N_CH-1:0] motor_cerrar,
  output logic [N_CH-1:0] falla,
  output logic            luz,
  output logic            alarma
);

  localparam int LW = $clog2(T_LUZ + 1);
  localparam logic [LW-1:0] LUZ_LOAD = LW'(T_LUZ);

  logic [1:0] op, sub;
  logic       sys_cmd, cmd_light, cmd_arm, cmd_disarm, cmd_close_all;

  assign op            = rx_data[3:2];
  assign sub           = rx_data[1:0];
  assign sys_cmd       = rx_valid && (op == OP_SYS);
  assign cmd_light     = sys_cmd && (sub == SYS_LIGHT);
  assign cmd_arm       = sys_cmd && (sub == SYS_ARM);
  assign cmd_disarm    = sys_cmd && (sub == SYS_DISARM);
  assign cmd_close_all = sys_cmd && (sub == SYS_CLOSE_ALL);

  // Channel numbers at or above N_CH match no instance and are dropped silently.
  for (genvar g = 0; g < N_CH; g++) begin : g_canal
    logic hit;
    assign hit = rx_valid && (sub == 2'(g));
    canal_porton #(
      .T_MOTOR(T_MOTOR),
      .T_DEAD (T_DEAD)
    ) u_canal (
      .clk           (clk),
      .rst           (rst),
      .cmd_open_i    (hit && (op == OP_OPEN)),
      .cmd_close_i   ((hit && (op == OP_CLOSE)) || cmd_close_all),
      .cmd_stop_i    (hit && (op == OP_STOP)),
      .abierto_i     (final_carrera_abierto[g]),
      .cerrado_i     (final_carrera_cerrado[g]),
      .motor_abrir_o (motor_abrir[g]),
      .motor_cerrar_o(motor_cerrar[g]),
      .falla_o       (falla[g])
    );
  end

  logic          toggle_q, toggle_d;
  logic          armed_q, armed_d;
  logic          alarma_q, alarma_d;
  logic          sensor_q;
  logic [LW-1:0] luz_cnt_q, luz_cnt_d;
  logic          luz_q;

  // An arm command counts as armed in its own cycle so a present intruder trips the very next cycle.
  always_comb begin
    toggle_d = toggle_q ^ cmd_light;
    armed_d  = armed_q;
    alarma_d = alarma_q;
    if (cmd_disarm) begin
      armed_d  = 1'b0;
      alarma_d = 1'b0;
    end else begin
      if (cmd_arm) armed_d = 1'b1;
      if ((armed_q || cmd_arm) && sensor) alarma_d = 1'b1;
    end
    if (sensor && !sensor_q)    luz_cnt_d = LUZ_LOAD;
    else if (luz_cnt_q != '0)   luz_cnt_d = luz_cnt_q - LW'(1);
    else                        luz_cnt_d = luz_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_q  <= 1'b0;
      armed_q   <= 1'b0;
      alarma_q  <= 1'b0;
      sensor_q  <= 1'b0;
      luz_cnt_q <= '0;
      luz_q     <= 1'b0;
    end else begin
      toggle_q  <= toggle_d;
      armed_q   <= armed_d;
      alarma_q  <= alarma_d;
      sensor_q  <= sensor;
      luz_cnt_q <= luz_cnt_d;
      luz_q     <= (luz_switch ^ toggle_d) | (luz_cnt_d != '0);
    end
  end

  assign luz    = luz_q;
  assign alarma = alarma_q;

endmodule

// File: tb/tb_control_porton_multi.sv
// tb/tb_control_porton_multi.sv - randomized and directed checks against a behavioural model
module tb_control_porton_multi;

  localparam int N_CH    = 2;
  localparam int T_MOTOR = 20;
  localparam int T_DEAD  = 4;
  localparam int T_LUZ   = 12;

  logic            clk;
  logic            rst;
  logic [3:0]      rx_data;
  logic            rx_valid;
  logic [N_CH-1:0] ab_v, ce_v;
  logic            luz_switch, sensor;
  logic [N_CH-1:0] motor_abrir, motor_cerrar, falla;
  logic            luz, alarma;

  control_porton_multi #(
    .N_CH(N_CH), .T_MOTOR(T_MOTOR), .T_DEAD(T_DEAD), .T_LUZ(T_LUZ)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .final_carrera_abierto(ab_v),
    .final_carrera_cerrado(ce_v),
    .luz_switch           (luz_switch),
    .sensor               (sensor),
    .motor_abrir          (motor_abrir),
    .motor_cerrar         (motor_cerrar),
    .falla                (falla),
    .luz                  (luz),
    .alarma               (alarma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gate model: direction of travel, cycles travelled, dead-time remaining, parked at a limit.
  int  m_mv[N_CH], m_age[N_CH], m_dead[N_CH], m_tgt[N_CH];
  bit  m_flt[N_CH], m_park[N_CH];
  bit  m_tg, m_armed, m_al, m_sprev, m_live;
  int  m_edge, cyc;
  logic [N_CH-1:0] e_ab, e_ce, e_fl;
  logic e_luz, e_al;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_mv[i] = 0; m_age[i] = 0; m_dead[i] = 0; m_tgt[i] = 0; m_flt[i] = 0; m_park[i] = 0;
    end
    m_tg = 0; m_armed = 0; m_al = 0; m_sprev = 0; m_edge = -1000000;
    e_ab = '0; e_ce = '0; e_fl = '0; e_luz = 0; e_al = 0;
  endtask

  task automatic model_step();
    int op, sub;
    bit o, c, s, ab, ce;
    op  = int'(rx_data[3:2]);
    sub = int'(rx_data[1:0]);
    for (int i = 0; i < N_CH; i++) begin
      o  = rx_valid && op == 0 && sub == i;
      c  = rx_valid && ((op == 1 && sub == i) || (op == 3 && sub == 3));
      s  = rx_valid && op == 2 && sub == i;
      ab = ab_v[i];
      ce = ce_v[i];
      if (ab && ce) begin
        m_flt[i] = 1; m_mv[i] = 0; m_dead[i] = 0; m_park[i] = 0;
      end else if (m_flt[i]) begin
        if (s) m_flt[i] = 0;
      end else if (s) begin
        m_mv[i] = 0; m_dead[i] = 0; m_park[i] = 0;
      end else if (m_dead[i] > 0) begin
        m_dead[i]--;
        if (m_dead[i] == 0) begin
          if (m_tgt[i] > 0 ? ab : ce) m_park[i] = 1;
          else begin m_mv[i] = m_tgt[i]; m_age[i] = 0; end
        end
      end else if (m_mv[i] != 0) begin
        m_age[i]++;
        if (m_mv[i] > 0 ? ab : ce) begin
          m_mv[i] = 0; m_park[i] = 1;
        end else if (m_age[i] >= T_MOTOR) begin
          m_mv[i] = 0; m_flt[i] = 1;
        end else if (m_mv[i] > 0 ? c : o) begin
          m_tgt[i] = -m_mv[i]; m_mv[i] = 0; m_dead[i] = T_DEAD;
        end
      end else begin
        if (!m_park[i] && (ab || ce)) m_park[i] = 1;
        else if (o && !ab) begin m_mv[i] = 1;  m_age[i] = 0; m_park[i] = 0; end
        else if (c && !ce) begin m_mv[i] = -1; m_age[i] = 0; m_park[i] = 0; end
      end
      e_ab[i] = m_mv[i] > 0;
      e_ce[i] = m_mv[i] < 0;
      e_fl[i] = m_flt[i];
    end
    if (rx_valid && op == 3 && sub == 0) m_tg = !m_tg;
    if (sensor && !m_sprev) m_edge = cyc;
    m_sprev = sensor;
    e_luz = (luz_switch ^ m_tg) || (cyc - m_edge < T_LUZ);
    if (rx_valid && op == 3 && sub == 2) begin
      m_armed = 0; m_al = 0;
    end else begin
      if (rx_valid && op == 3 && sub == 1) m_armed = 1;
      if (m_armed && sensor) m_al = 1;
    end
    e_al = m_al;
  endtask

  initial begin
    m_live = 0;
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        model_reset();
        m_live = 1;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("outputs_vs_model", 32'({motor_abrir, motor_cerrar, falla, luz, alarma}),
              32'({e_ab, e_ce, e_fl, e_luz, e_al}));
        check("motor_mutex", 32'(motor_abrir & motor_cerrar), 32'(0));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    step(1);
    rx_valid = 1'b0;
    rx_data  = 4'h0;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 4'h0;
    ab_v = '0; ce_v = '0; luz_switch = 1'b0; sensor = 1'b0;
    step(2);
    check("reset_outputs", 32'({motor_abrir, motor_cerrar, falla, luz, alarma}), 32'(0));
    rst = 1'b0;

    // open ch0, limit reached after 8 motion cycles
    cmd(4'h0);
    check("open0_start", 32'(motor_abrir), 32'h1);
    step(7);
    check("open0_running", 32'(motor_abrir), 32'h1);
    ab_v[0] = 1'b1;
    step(1);
    check("open0_limit_drop", 32'(motor_abrir), 32'h0);
    ab_v[0] = 1'b0;

    // reversal on ch1 through the dead-time
    cmd(4'h5);
    check("close1_start", 32'(motor_cerrar), 32'h2);
    step(3);
    cmd(4'h1);
    check("dead_first", 32'({motor_abrir, motor_cerrar}), 32'h0);
    step(3);
    check("dead_last", 32'({motor_abrir, motor_cerrar}), 32'h0);
    step(1);
    check("reverse_open1", 32'(motor_abrir), 32'h2);
    cmd(4'h9);
    check("stop1", 32'(motor_abrir), 32'h0);

    // motion timeout on ch0
    cmd(4'h0);
    step(19);
    check("timeout_last_motion", 32'({motor_abrir[0], falla[0]}), 32'h2);
    step(1);
    check("timeout_fault", 32'({motor_abrir[0], falla[0]}), 32'h1);
    cmd(4'h8);
    check("fault_cleared", 32'(falla), 32'h0);

    // both limits on ch1
    ab_v[1] = 1'b1; ce_v[1] = 1'b1;
    step(1);
    check("dual_limit_fault", 32'({motor_abrir, motor_cerrar, falla}), 32'h02);
    ab_v[1] = 1'b0; ce_v[1] = 1'b0;
    cmd(4'h9);
    check("dual_fault_cleared", 32'(falla), 32'h0);

    // alarm and light timer
    cmd(4'hD);
    check("armed_quiet", 32'(alarma), 32'h0);
    sensor = 1'b1;
    step(1);
    check("alarm_trip", 32'({alarma, luz}), 32'h3);
    sensor = 1'b0;
    step(11);
    check("luz_last_cycle", 32'({alarma, luz}), 32'h3);
    step(1);
    check("luz_expired", 32'({alarma, luz}), 32'h2);
    cmd(4'hE);
    check("disarm_clear", 32'(alarma), 32'h0);
    sensor = 1'b1;
    cmd(4'hD);
    check("arm_with_sensor", 32'(alarma), 32'h1);
    cmd(4'hE);
    check("disarm_wins", 32'(alarma), 32'h0);
    step(1);
    check("stays_disarmed", 32'(alarma), 32'h0);
    sensor = 1'b0;
    step(14);
    cmd(4'hC);
    check("toggle_on", 32'(luz), 32'h1);
    cmd(4'hC);
    check("toggle_off", 32'(luz), 32'h0);
    luz_switch = 1'b1;
    step(1);
    check("wall_switch", 32'(luz), 32'h1);
    luz_switch = 1'b0;

    // out-of-range channel, then close-all
    cmd(4'h7);
    check("ch3_ignored", 32'({motor_abrir, motor_cerrar, falla}), 32'h0);
    cmd(4'hF);
    check("close_all", 32'({motor_abrir, motor_cerrar}), 32'h3);
    cmd(4'h8);
    cmd(4'h9);

    // reset mid-motion
    cmd(4'h0);
    rst = 1'b1;
    step(1);
    check("rst_mid_motion", 32'({motor_abrir, motor_cerrar, falla, luz, alarma}), 32'h0);
    rst = 1'b0;

    for (int k = 0; k < 4000; k++) begin
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 4'($urandom_range(0, 15));
      for (int i = 0; i < N_CH; i++) begin
        if (ab_v[i] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0)) ab_v[i] = ~ab_v[i];
        if (ce_v[i] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0)) ce_v[i] = ~ce_v[i];
      end
      if ($urandom_range(0, 9) == 0)  sensor = ~sensor;
      if ($urandom_range(0, 29) == 0) luz_switch = ~luz_switch;
      rst = ($urandom_range(0, 599) == 0);
      step(1);
    end
    rst = 1'b0;
    rx_valid = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
